pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 27 ++
 rtl/pc_unit_if.sv | 36 +++
 rtl/pc_next_mux.sv | 40 ++++
 rtl/pc_unit.sv | 66 ++++++
 tb/tb_pc_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the program-counter slice.
//   XLEN      : datapath width (32)
//   pc_sel_e  : next-PC source select encodings
//   jalr_target() : jalr address formation (sum with bit 0 cleared)
package pc_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        PC_SEL_SEQ    = 3'd0,
        PC_SEL_JAL    = 3'd1,
        PC_SEL_JALR   = 3'd2,
        PC_SEL_BR     = 3'd3,
        PC_SEL_REPLAY = 3'd4,
        PC_SEL_TRAP   = 3'd5,
        PC_SEL_ERET   = 3'd6,
        PC_SEL_HOLD   = 3'd7
    } pc_sel_e;

    function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                    input logic [XLEN-1:0] offset);
        logic [XLEN-1:0] sum;
        sum = base + offset;
        return {sum[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: bundle of the next-PC select, its operands and the registered PC.
//   master : drives select/operands, observes PC_PIF (pipeline control side)
//   slave  : receives select/operands, drives PC_PIF (pc register side)
//   mux    : read-only view used by the combinational next-PC logic
interface pc_unit_if;
    import pc_pkg::*;

    logic [2:0]      PC_src_sel;
    logic [XLEN-1:0] PC_DX;
    logic [XLEN-1:0] jal_offset;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] jalr_offset;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] PC_IF;
    logic [XLEN-1:0] handler_PC;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] PC_PIF;

    modport master (
        output PC_src_sel, PC_DX, jal_offset, rs1_data, jalr_offset,
               imm_b, PC_IF, handler_PC, epc,
        input  PC_PIF
    );

    modport slave (
        input  PC_src_sel, PC_DX, jal_offset, rs1_data, jalr_offset,
               imm_b, PC_IF, handler_PC, epc,
        output PC_PIF
    );

    modport mux (
        input PC_src_sel, PC_DX, jal_offset, rs1_data, jalr_offset,
              imm_b, PC_IF, handler_PC, epc, PC_PIF
    );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: purely combinational next-PC formation (adders + 8:1 select).
//   bus     : pc_unit_if.mux view (select, operands, current PC_PIF)
//   next_pc : value to load into PC_PIF on the next rising edge
// All sums are modulo 2^32; no alignment checking beyond the jalr bit-0 clear.
module pc_next_mux
    import pc_pkg::*;
(
    pc_unit_if.mux         bus,
    output logic [XLEN-1:0] next_pc
);

    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] jal_target;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jr_target;

    always_comb begin
        seq_target = bus.PC_PIF + 32'd4;
        jal_target = bus.PC_DX + bus.jal_offset;
        br_target  = bus.PC_DX + bus.imm_b;
        jr_target  = jalr_target(bus.rs1_data, bus.jalr_offset);
    end

    // An unknown select falls to the default arm and holds the current PC.
    always_comb begin
        next_pc = bus.PC_PIF;
        case (pc_sel_e'(bus.PC_src_sel))
            PC_SEL_SEQ:    next_pc = seq_target;
            PC_SEL_JAL:    next_pc = jal_target;
            PC_SEL_JALR:   next_pc = jr_target;
            PC_SEL_BR:     next_pc = br_target;
            PC_SEL_REPLAY: next_pc = bus.PC_IF;
            PC_SEL_TRAP:   next_pc = bus.handler_PC;
            PC_SEL_ERET:   next_pc = bus.epc;
            PC_SEL_HOLD:   next_pc = bus.PC_PIF;
            default:       next_pc = bus.PC_PIF;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: pre-fetch program counter register.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset, loads RESET_VECTOR
//   PC_src_sel   : next-PC source select (see pc_pkg::pc_sel_e)
//   PC_DX        : decode/execute PC, base for jal and branch
//   jal_offset   : sign-extended J-immediate
//   rs1_data     : jalr base register
//   jalr_offset  : sign-extended I-immediate
//   imm_b        : sign-extended B-immediate
//   PC_IF        : fetch-stage PC, used for replay
//   handler_PC   : trap handler address
//   epc          : trap return address
//   PC_PIF       : registered next fetch address (one cycle latency)
// Flat ports are kept for drop-in compatibility; they are gathered into a
// local pc_unit_if instance so the next-PC logic sees a single bundle.
module pc_unit
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      PC_src_sel,
    output logic [XLEN-1:0] PC_PIF,
    input  logic [XLEN-1:0] PC_DX,
    input  logic [XLEN-1:0] jal_offset,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] jalr_offset,
    input  logic [XLEN-1:0] imm_b,
    input  logic [XLEN-1:0] PC_IF,
    input  logic [XLEN-1:0] handler_PC,
    input  logic [XLEN-1:0] epc
);

    pc_unit_if bus ();

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_q;

    assign bus.PC_src_sel  = PC_src_sel;
    assign bus.PC_DX       = PC_DX;
    assign bus.jal_offset  = jal_offset;
    assign bus.rs1_data    = rs1_data;
    assign bus.jalr_offset = jalr_offset;
    assign bus.imm_b       = imm_b;
    assign bus.PC_IF       = PC_IF;
    assign bus.handler_PC  = handler_PC;
    assign bus.epc         = epc;
    assign bus.PC_PIF      = pc_q;

    pc_next_mux u_next (
        .bus     (bus),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= next_pc;
        end
    end

    assign PC_PIF = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic clk;
    logic rst;

    pc_unit_if bus ();

    pc_unit #(
        .RESET_VECTOR (RV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PC_src_sel  (bus.PC_src_sel),
        .PC_PIF      (bus.PC_PIF),
        .PC_DX       (bus.PC_DX),
        .jal_offset  (bus.jal_offset),
        .rs1_data    (bus.rs1_data),
        .jalr_offset (bus.jalr_offset),
        .imm_b       (bus.imm_b),
        .PC_IF       (bus.PC_IF),
        .handler_PC  (bus.handler_PC),
        .epc         (bus.epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] dx;
        logic [31:0] jal;
        logic [31:0] rs1;
        logic [31:0] jalr;
        logic [31:0] immb;
        logic [31:0] pcif;
        logic [31:0] hnd;
        logic [31:0] epc;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    // Reference: the architectural next-PC rules, independent of the RTL.
    function automatic logic [31:0] ref_next(input logic [2:0] sel, input logic [31:0] pc,
                                             input logic [31:0] dx, input logic [31:0] jal,
                                             input logic [31:0] rs1, input logic [31:0] jalr,
                                             input logic [31:0] immb, input logic [31:0] pcif,
                                             input logic [31:0] hnd, input logic [31:0] ep);
        longint unsigned s;
        case (sel)
            3'd0: s = longint'(pc) + 4;
            3'd1: s = longint'(dx) + longint'(jal);
            3'd2: begin
                s = longint'(rs1) + longint'(jalr);
                s = s - (s % 2);
            end
            3'd3: s = longint'(dx) + longint'(immb);
            3'd4: s = longint'(pcif);
            3'd5: s = longint'(hnd);
            3'd6: s = longint'(ep);
            default: s = longint'(pc);
        endcase
        return 32'(s % 64'h1_0000_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: PC_PIF=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.PC_src_sel  = v.sel;
        bus.PC_DX       = v.dx;
        bus.jal_offset  = v.jal;
        bus.rs1_data    = v.rs1;
        bus.jalr_offset = v.jalr;
        bus.imm_b       = v.immb;
        bus.PC_IF       = v.pcif;
        bus.handler_PC  = v.hnd;
        bus.epc         = v.epc;
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] sel, input logic [31:0] exp);
        vec_t v;
        v.name = name; v.sel = sel; v.exp = exp;
        v.dx = '0; v.jal = '0; v.rs1 = '0; v.jalr = '0; v.immb = '0;
        v.pcif = '0; v.hnd = '0; v.epc = '0;
        return v;
    endfunction

    logic [31:0] exp_pc;
    vec_t        rv;

    initial begin
        // Directed table, applied from PC_PIF = RESET_VECTOR (0).
        vecs[0]  = mk("seq1", 3'd0, 32'h4);
        vecs[1]  = mk("seq2", 3'd0, 32'h8);
        vecs[2]  = mk("seq3", 3'd0, 32'hC);
        vecs[3]  = mk("jal",  3'd1, 32'h0F0);
        vecs[3].dx = 32'h100; vecs[3].jal = 32'hFFFF_FFF0;
        vecs[4]  = mk("branch", 3'd3, 32'h120);
        vecs[4].dx = 32'h100; vecs[4].immb = 32'h20;
        vecs[5]  = mk("jalr_odd", 3'd2, 32'h1002);
        vecs[5].rs1 = 32'h1001; vecs[5].jalr = 32'h2;
        vecs[6]  = mk("jalr_clr", 3'd2, 32'h2);
        vecs[6].rs1 = 32'h3;
        vecs[7]  = mk("trap", 3'd5, 32'h8000_0000);
        vecs[7].hnd = 32'h8000_0000;
        vecs[8]  = mk("eret", 3'd6, 32'h44);
        vecs[8].epc = 32'h44;
        vecs[9]  = mk("replay", 3'd4, 32'h58);
        vecs[9].pcif = 32'h58;
        vecs[10] = mk("hold", 3'd7, 32'h58);
        vecs[10].hnd = 32'h1234; vecs[10].epc = 32'h5678;
        vecs[11] = mk("seq_after_hold", 3'd0, 32'h5C);
        vecs[12] = mk("jalr_wrap", 3'd2, 32'hFFFF_FFFC);
        vecs[12].rs1 = 32'hFFFF_FFFF; vecs[12].jalr = 32'hFFFF_FFFE;
        vecs[13] = mk("seq_wrap", 3'd0, 32'h0);
        vecs[14] = mk("trap_misaligned", 3'd5, 32'h3);
        vecs[14].hnd = 32'h3;
        vecs[15] = mk("seq_misaligned", 3'd0, 32'h7);

        // Reset with an undriven select.
        drive(mk("idle", 3'd0, '0));
        bus.PC_src_sel = 3'bxxx;
        rst = 1'b0;
        #1;
        check("reset_async", bus.PC_PIF, RV);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_across_edges", bus.PC_PIF, RV);
        @(negedge clk);
        bus.PC_src_sel = 3'd0;
        rst = 1'b1;
        #1;
        check("reset_release_no_update", bus.PC_PIF, RV);

        exp_pc = RV;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check(vecs[i].name, bus.PC_PIF, vecs[i].exp);
            exp_pc = vecs[i].exp;
            @(negedge clk);
        end

        // Async reset mid-cycle with a pending sequential update.
        rv = mk("pending", 3'd1, '0);
        rv.dx = 32'h4000; rv.jal = 32'h10;
        drive(rv);
        @(posedge clk);
        #1;
        check("pre_reset_jal", bus.PC_PIF, 32'h4010);
        #2;
        rst = 1'b0;
        #1;
        check("mid_cycle_reset", bus.PC_PIF, RV);
        @(posedge clk);
        #1;
        check("reset_discards_pending", bus.PC_PIF, RV);
        @(negedge clk);
        rst = 1'b1;
        drive(mk("first_after_reset", 3'd0, '0));
        @(posedge clk);
        #1;
        check("first_update_after_reset", bus.PC_PIF, RV + 32'd4);
        exp_pc = RV + 32'd4;
        @(negedge clk);

        // Random regression against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] e;
            rv = mk("rand", 3'($urandom_range(0, 7)), '0);
            rv.dx   = $urandom;
            rv.jal  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            rv.rs1  = $urandom;
            rv.jalr = $urandom;
            rv.immb = $urandom;
            rv.pcif = $urandom;
            rv.hnd  = $urandom;
            rv.epc  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            e = ref_next(rv.sel, exp_pc, rv.dx, rv.jal, rv.rs1, rv.jalr,
                         rv.immb, rv.pcif, rv.hnd, rv.epc);
            drive(rv);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_sel%0d", i, rv.sel), bus.PC_PIF, e);
            exp_pc = e;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
